// File: rtl/pixel_write_fifo_if.sv
// Pixel-write command bus between the host/command side and the pixel FIFO.
// The master drives push/pop/clr_err and the write data. The slave (the FIFO)
// returns the head entry, the flags, the occupancy and the sticky errors.
interface pixel_write_fifo_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10,
  parameter int DEPTH   = 16
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic                 push;
  logic [X_WIDTH-1:0]   x_in;
  logic [Y_WIDTH-1:0]   y_in;
  logic [2:0]           rgb_in;
  logic                 pop;
  logic                 clr_err;
  logic [X_WIDTH-1:0]   x_out;
  logic [Y_WIDTH-1:0]   y_out;
  logic [2:0]           rgb_out;
  logic                 fifoempty;
  logic                 full;
  logic [PTR_WIDTH:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, x_in, y_in, rgb_in, pop, clr_err,
    input  x_out, y_out, rgb_out, fifoempty, full, count, overflow, underflow
  );

  modport slave (
    input  push, x_in, y_in, rgb_in, pop, clr_err,
    output x_out, y_out, rgb_out, fifoempty, full, count, overflow, underflow
  );
endinterface

// File: rtl/pixel_write_fifo.sv
// pixel_write_fifo: show-ahead FIFO that buffers {x, y, rgb} pixel writes
// until the RGB memory codec commits them during blanking. The head entry is
// read asynchronously, so the codec sees it with no pop latency. Flags and
// count are registered and derived from the next occupancy.
//
// Optional build macro PIXFIFO_DROP_OLDEST_EN: when it is defined, a push
// while full is accepted and overwrites the oldest entry. Overflow still
// records the loss. When it is undefined, a push while full is rejected.
module pixel_write_fifo #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10,
  parameter int DEPTH   = 16
) (
  input logic              clk,
  input logic              reset,
  pixel_write_fifo_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int ENTRY_W   = X_WIDTH + Y_WIDTH + 3;
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_ONE    = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   head;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count_q;
  logic [PTR_WIDTH:0]   next_count;
  logic                 empty_q;
  logic                 full_q;
  logic                 overflow_q;
  logic                 underflow_q;
  logic                 push_ok;
  logic                 rd_adv;
  logic                 ovf_evt;
  logic                 udf_evt;

  // Decide which strobes take effect this edge and the occupancy that follows.
  always_comb begin
    push_ok    = 1'b0;
    rd_adv     = 1'b0;
    ovf_evt    = bus.push & full_q;
    udf_evt    = bus.pop & empty_q;
    next_count = count_q;
`ifdef PIXFIFO_DROP_OLDEST_EN
    // A push while full still lands. The read side moves past the oldest
    // entry, which is either the one being popped or the one being dropped.
    push_ok = bus.push;
    rd_adv  = (bus.pop & ~empty_q) | (bus.push & full_q);
`else
    push_ok = bus.push & ~full_q;
    rd_adv  = bus.pop & ~empty_q;
`endif
    case ({push_ok, rd_adv})
      2'b10:   next_count = count_q + CNT_ONE;
      2'b01:   next_count = count_q - CNT_ONE;
      default: next_count = count_q;
    endcase
  end

  // Storage write at the tail. The array itself is never cleared.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= {bus.x_in, bus.y_in, bus.rgb_in};
    end
  end

  // Pointers, registered flags, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q     <= next_count;
      empty_q     <= (next_count == '0);
      full_q      <= (next_count == FULL_COUNT);
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow_q  <= ovf_evt | (overflow_q & ~bus.clr_err);
      underflow_q <= udf_evt | (underflow_q & ~bus.clr_err);
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.x_out     = head[ENTRY_W-1 -: X_WIDTH];
  assign bus.y_out     = head[3 +: Y_WIDTH];
  assign bus.rgb_out   = head[2:0];
  assign bus.fifoempty = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_pixel_write_fifo.sv
// Testbench for pixel_write_fifo. The stimulus process drives the inputs just
// after each rising edge. A reference process samples the same inputs at the
// rising edge and replays them on a queue of entries. A monitor on the falling
// edge compares the DUT head, flags, count and errors against that queue.
module tb_pixel_write_fifo;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    rgb;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  ent_t exp_q[$];
  bit   exp_ovf = 1'b0;
  bit   exp_udf = 1'b0;

  pixel_write_fifo_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .DEPTH(DEPTH)) bus();

  pixel_write_fifo #(.X_WIDTH(XW), .Y_WIDTH(YW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is simply an ordered queue of entries.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
      end else begin
        bit was_full;
        bit was_empty;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (bus.pop && !was_empty) void'(exp_q.pop_front());
`ifdef PIXFIFO_DROP_OLDEST_EN
        if (bus.push) begin
          if (exp_q.size() == DEPTH) void'(exp_q.pop_front());
          exp_q.push_back(ent_t'{bus.x_in, bus.y_in, bus.rgb_in});
        end
`else
        if (bus.push && !was_full) exp_q.push_back(ent_t'{bus.x_in, bus.y_in, bus.rgb_in});
`endif
        exp_ovf = (bus.push && was_full) || (exp_ovf && !bus.clr_err);
        exp_udf = (bus.pop && was_empty) || (exp_udf && !bus.clr_err);
      end
    end
  end

  // Monitor: compare the DUT state against the reference queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count", 32'(bus.count), 32'(exp_q.size()));
        check("fifoempty", 32'(bus.fifoempty), 32'(exp_q.size() == 0));
        check("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check("underflow", 32'(bus.underflow), 32'(exp_udf));
        if (exp_q.size() != 0) begin
          check("x_out", 32'(bus.x_out), 32'(exp_q[0].x));
          check("y_out", 32'(bus.y_out), 32'(exp_q[0].y));
          check("rgb_out", 32'(bus.rgb_out), 32'(exp_q[0].rgb));
        end
      end
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic cyc(input bit p, input int x, input int y, input int rgb,
                     input bit po, input bit clr, input bit r);
    bus.push    = p;
    bus.x_in    = XW'(x);
    bus.y_in    = YW'(y);
    bus.rgb_in  = 3'(rgb);
    bus.pop     = po;
    bus.clr_err = clr;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.rgb_in = '0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;
    idle();
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_empty", 32'(bus.fifoempty), 32'd1);

    // Pop while empty.
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("udf_after_pop_empty", 32'(bus.underflow), 32'd1);
    check("count_after_pop_empty", 32'(bus.count), 32'd0);

    // Single entry in and out.
    cyc(1, 5, 7, 3'b101, 0, 1, 0);
    check("single_x", 32'(bus.x_out), 32'd5);
    check("single_y", 32'(bus.y_out), 32'd7);
    check("single_rgb", 32'(bus.rgb_out), 32'b101);
    check("single_count", 32'(bus.count), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("single_pop_empty", 32'(bus.fifoempty), 32'd1);

    // Fill, overfill with x=99, drain.
    for (int i = 0; i < DEPTH; i++) cyc(1, i, i + 100, i, 0, 0, 0);
    check("fill_full", 32'(bus.full), 32'd1);
    cyc(1, 99, 99, 7, 0, 0, 0);
    check("overfill_ovf", 32'(bus.overflow), 32'd1);
    check("overfill_count", 32'(bus.count), 32'(DEPTH));
`ifdef PIXFIFO_DROP_OLDEST_EN
    check("overfill_head", 32'(bus.x_out), 32'd1);
`else
    check("overfill_head", 32'(bus.x_out), 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    check("drained_empty", 32'(bus.fifoempty), 32'd1);

    // Full with simultaneous push and pop, then push+pop at half occupancy.
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, i + 200, i, 2, 0, 0, 0);
    cyc(1, 300, 1, 1, 1, 0, 0);
`ifdef PIXFIFO_DROP_OLDEST_EN
    check("full_pushpop_count", 32'(bus.count), 32'(DEPTH));
`else
    check("full_pushpop_count", 32'(bus.count), 32'(DEPTH - 1));
`endif
    check("full_pushpop_ovf", 32'(bus.overflow), 32'd1);
    check("full_pushpop_head", 32'(bus.x_out), 32'd201);
    while (bus.count > 8) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 301, 2, 4, 1, 0, 0);
    check("half_pushpop_count", 32'(bus.count), 32'd8);
    while (!bus.fifoempty) cyc(0, 0, 0, 0, 1, 0, 0);

    // Randomised interleave across many pointer wraps with biased phases.
    for (int i = 0; i < 280; i++) begin
      int pp;
      int pq;
      pp = (i < 40) ? 50 : ((i / 60) % 2 == 0) ? 80 : 25;
      pq = 100 - pp;
      cyc($urandom_range(99) < pp, $urandom_range(1023), $urandom_range(1023),
          $urandom_range(7), $urandom_range(99) < pq, $urandom_range(99) < 5, 0);
    end

    // Reset mid-stream together with a push.
    while (!bus.fifoempty) cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, i + 40, i, 3, 0, 0, 0);
    cyc(1, 555, 5, 5, 0, 0, 1);
    check("rst_mid_count", 32'(bus.count), 32'd0);
    check("rst_mid_empty", 32'(bus.fifoempty), 32'd1);
    idle();
    check("rst_mid_still_empty", 32'(bus.fifoempty), 32'd1);

    // Provoke overflow, then clear it.
    for (int i = 0; i <= DEPTH; i++) cyc(1, i, i, 6, 0, 0, 0);
    check("ovf_before_clr", 32'(bus.overflow), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("ovf_after_clr", 32'(bus.overflow), 32'd0);
    // clr_err with a concurrent overflow keeps the flag set.
    cyc(1, 9, 9, 1, 0, 1, 0);
    check("ovf_set_wins", 32'(bus.overflow), 32'd1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
